// File: rtl/cdc_mcp_rx.sv
// ============================================================================
// Module   : cdc_mcp_rx
// Purpose  : MCP CDC receiver. Each channel synchronises its toggle, captures
//            source-held data and returns an acknowledge toggle on transfer.
// Options  : `define CDC_MCP_RX_OVERRUN_EN adds sticky overrun flags and keeps
//            the first value on overrun instead of overwriting it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_mcp_rx #(
   parameter int WIDTH       = 8,
   parameter int CHANNELS    = 2,
   parameter int SYNC_STAGES = 2   // must be >= 2
) (
   input  logic                      CLK_I,
   input  logic                      RST_I,
   input  logic [CHANNELS-1:0]       TOGGLE_I,
   input  logic [CHANNELS*WIDTH-1:0] DATA_I,
   output logic [CHANNELS*WIDTH-1:0] DATA_O,
   output logic [CHANNELS-1:0]       VALID_O,
   input  logic [CHANNELS-1:0]       READY_I,
   output logic [CHANNELS-1:0]       ACK_O
`ifdef CDC_MCP_RX_OVERRUN_EN
   ,
   output logic [CHANNELS-1:0]       OVERRUN_O,
   input  logic [CHANNELS-1:0]       OVERRUN_CLR_I
`endif
);

   genvar c;
   generate
      for (c = 0; c < CHANNELS; c++) begin : g_ch
         logic [SYNC_STAGES:0] r_sync;
         logic [WIDTH-1:0]     r_data;
         logic                 r_valid;
         logic                 r_ack;
         logic                 w_ld;
         logic                 w_xfer;
         logic                 w_capture;

         always_ff @(posedge CLK_I or posedge RST_I) begin
            if (RST_I) r_sync <= '0;
            else       r_sync <= {r_sync[SYNC_STAGES-1:0], TOGGLE_I[c]};
         end

         // Extra stage past the synchroniser gives a pulse on either toggle edge.
         assign w_ld   = r_sync[SYNC_STAGES-1] ^ r_sync[SYNC_STAGES];
         assign w_xfer = r_valid & READY_I[c];

`ifdef CDC_MCP_RX_OVERRUN_EN
         logic w_overrun;
         logic r_overrun;

         assign w_overrun = w_ld & r_valid & ~READY_I[c];
         assign w_capture = w_ld & ~w_overrun;

         always_ff @(posedge CLK_I or posedge RST_I) begin
            if (RST_I)                 r_overrun <= 1'b0;
            else if (w_overrun)        r_overrun <= 1'b1;
            else if (OVERRUN_CLR_I[c]) r_overrun <= 1'b0;
         end

         assign OVERRUN_O[c] = r_overrun;
`else
         assign w_capture = w_ld;
`endif

         always_ff @(posedge CLK_I or posedge RST_I) begin
            if (RST_I) begin
               r_data  <= '0;
               r_valid <= 1'b0;
               r_ack   <= 1'b0;
            end else begin
               if (w_capture)   r_data <= DATA_I[c*WIDTH +: WIDTH];
               if (w_ld)        r_valid <= 1'b1;
               else if (w_xfer) r_valid <= 1'b0;
               // Only an accepted transfer releases the source, so overruns yield one ack.
               if (w_xfer)      r_ack <= ~r_ack;
            end
         end

         assign DATA_O[c*WIDTH +: WIDTH] = r_data;
         assign VALID_O[c]               = r_valid;
         assign ACK_O[c]                 = r_ack;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cdc_mcp_rx.sv
// ============================================================================
// Module   : tb_cdc_mcp_rx
// Purpose  : Directed self-checking bench for cdc_mcp_rx (4 channels, 8 bits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdc_mcp_rx;

   localparam int W  = 8;
   localparam int CH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [CH-1:0]   tog;
   logic [CH*W-1:0] din;
   logic [CH*W-1:0] dout;
   logic [CH-1:0]   valid;
   logic [CH-1:0]   rdy;
   logic [CH-1:0]   ack;
`ifdef CDC_MCP_RX_OVERRUN_EN
   logic [CH-1:0]   ovr;
   logic [CH-1:0]   ovr_clr;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cdc_mcp_rx #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(2)) u_dut (
      .CLK_I    (clk),
      .RST_I    (rst),
      .TOGGLE_I (tog),
      .DATA_I   (din),
      .DATA_O   (dout),
      .VALID_O  (valid),
      .READY_I  (rdy),
      .ACK_O    (ack)
`ifdef CDC_MCP_RX_OVERRUN_EN
      ,
      .OVERRUN_O     (ovr),
      .OVERRUN_CLR_I (ovr_clr)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [W-1:0] slice(input int c);
      return dout[c*W +: W];
   endfunction

   initial begin
      rst = 1'b1;
      tog = '0;
      din = '0;
      rdy = '0;
`ifdef CDC_MCP_RX_OVERRUN_EN
      ovr_clr = '0;
`endif
      tick(3);
      chk("rst_data",  dout,  32'h0);
      chk("rst_valid", valid, 4'h0);
      chk("rst_ack",   ack,   4'h0);
      rst = 1'b0;
      tick(2);

      // Basic rising toggle on channel 0, consumer always ready
      din[0 +: W] = 8'hA5;
      tog[0]      = 1'b1;
      rdy         = 4'b0001;
      tick(2);
      chk("lat_valid_e2", valid[0], 1'b0);
      tick(1);
      chk("basic_valid", valid[0], 1'b1);
      chk("basic_data",  slice(0), 8'hA5);
      chk("basic_ack0",  ack[0],   1'b0);
      tick(1);
      chk("basic_clr",   valid[0], 1'b0);
      chk("basic_ack1",  ack[0],   1'b1);

      // Falling toggle edge
      din[0 +: W] = 8'h3C;
      tog[0]      = 1'b0;
      tick(3);
      chk("fall_valid", valid[0], 1'b1);
      chk("fall_data",  slice(0), 8'h3C);
      tick(1);
      chk("fall_clr",   valid[0], 1'b0);
      chk("fall_ack",   ack[0],   1'b0);

      // Backpressure
      rdy         = 4'b0000;
      din[0 +: W] = 8'h11;
      tog[0]      = 1'b1;
      tick(3);
      tick(10);
      chk("bp_valid", valid[0], 1'b1);
      chk("bp_data",  slice(0), 8'h11);
      chk("bp_ack",   ack[0],   1'b0);
      rdy[0] = 1'b1;
      tick(1);
      chk("bp_clr",   valid[0], 1'b0);
      chk("bp_ack_t", ack[0],   1'b1);
      tick(3);
      chk("idle_ready_ack", ack[0], 1'b1);
      rdy = 4'b0000;

      // Overrun: second toggle while first value is unconsumed
      tog[0] = 1'b0;
      tick(3);
      chk("ovr_first", slice(0), 8'h11);
      din[0 +: W] = 8'h22;
      tog[0]      = 1'b1;
      tick(3);
      chk("ovr_valid", valid[0], 1'b1);
      chk("ovr_ack",   ack[0],   1'b1);
`ifdef CDC_MCP_RX_OVERRUN_EN
      chk("ovr_data",  slice(0), 8'h11);
      chk("ovr_flag",  ovr[0],   1'b1);
`else
      chk("ovr_data",  slice(0), 8'h22);
`endif
      rdy[0] = 1'b1;
      tick(1);
      chk("ovr_clr_v", valid[0], 1'b0);
      chk("ovr_ack_t", ack[0],   1'b0);
      rdy = 4'b0000;
      tick(1);
      chk("ovr_ack_once", ack[0], 1'b0);
`ifdef CDC_MCP_RX_OVERRUN_EN
      chk("ovr_sticky", ovr[0], 1'b1);
      ovr_clr[0] = 1'b1;
      tick(1);
      ovr_clr[0] = 1'b0;
      chk("ovr_cleared", ovr[0], 1'b0);
`endif

      // Capture and transfer on the same edge (channel 1)
      din[W +: W] = 8'h55;
      tog[1]      = 1'b1;
      tick(3);
      chk("sim_first", slice(1), 8'h55);
      din[W +: W] = 8'h66;
      tog[1]      = 1'b0;
      tick(2);
      rdy[1] = 1'b1;
      tick(1);
      chk("sim_valid", valid[1], 1'b1);
      chk("sim_data",  slice(1), 8'h66);
      chk("sim_ack",   ack[1],   1'b1);
      tick(1);
      chk("sim_clr",   valid[1], 1'b0);
      chk("sim_ack2",  ack[1],   1'b0);
      rdy = 4'b0000;

      // Multi-channel: channels 0 and 3 together, only 3 ready
      din[0 +: W]   = 8'h01;
      din[3*W +: W] = 8'h04;
      tog[0]        = 1'b0;
      tog[3]        = 1'b1;
      rdy           = 4'b1000;
      tick(3);
      chk("mc_valid", valid, 4'b1001);
      chk("mc_d3",    slice(3), 8'h04);
      tick(1);
      chk("mc_valid2", valid,    4'b0001);
      chk("mc_ack",    ack,      4'b1000);
      chk("mc_d0",     slice(0), 8'h01);
      rdy = 4'b0000;

      // Reset mid-operation
      din[2*W +: W] = 8'h33;
      tog[2]        = 1'b1;
      tick(3);
      chk("pre_rst_valid", valid, 4'b0101);
      tog[1] = 1'b1;
      tick(1);
      #2;
      rst = 1'b1;
      tog = '0;
      #1;
      chk("arst_data",  dout,  32'h0);
      chk("arst_valid", valid, 4'h0);
      chk("arst_ack",   ack,   4'h0);
      tick(2);
      rst = 1'b0;
      tick(5);
      chk("post_rst_valid", valid, 4'h0);
      chk("post_rst_data",  dout,  32'h0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
